// File: rtl/pkt_id_pkg.sv
// Shared definitions for the packet identifier front end: generation codes,
// link-state encoding and the lane/width helper functions.
package pkt_id_pkg;

  localparam logic [2:0] GEN1 = 3'd0;
  localparam logic [2:0] GEN2 = 3'd1;
  localparam logic [2:0] GEN3 = 3'd2;
  localparam logic [2:0] GEN4 = 3'd3;
  localparam logic [2:0] GEN5 = 3'd4;

  typedef enum logic [1:0] {
    DOWN   = 2'd0,
    SETTLE = 2'd1,
    ACTIVE = 2'd2,
    ERR    = 2'd3
  } link_state_t;

  // PIPE bits per lane, indexed by generation code
  typedef logic [4:0][7:0] pipe_widths_t;

  function automatic logic lane_legal(input logic [4:0] lanes, input logic [4:0] max_lanes);
    return (lanes != 5'd0) && ((lanes & (lanes - 5'd1)) == 5'd0) && (lanes <= max_lanes);
  endfunction

  function automatic logic [7:0] bytes_per_beat(input logic [2:0] gen, input logic [4:0] lanes,
                                                input pipe_widths_t widths);
    logic [7:0] lane_bytes;
    lane_bytes = (gen <= GEN5) ? (widths[gen] >> 3) : 8'd0;
    return lane_bytes * {3'b000, lanes};
  endfunction

endpackage

// File: rtl/gen_lane_mask.sv
// Combinational generation/lane decode: byte count per beat, per-byte valid
// mask and legality of the requested configuration.
module gen_lane_mask
  import pkt_id_pkg::*;
#(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int BUS_BYTES      = 64,
  parameter int MAX_LANES      = 16
) (
  input  logic [2:0]           gen,
  input  logic [4:0]           lanes,
  output logic [7:0]           bytes,
  output logic [BUS_BYTES-1:0] mask,
  output logic                 legal
);

  localparam pipe_widths_t WIDTHS = {8'(GEN5_PIPEWIDTH), 8'(GEN4_PIPEWIDTH), 8'(GEN3_PIPEWIDTH),
                                     8'(GEN2_PIPEWIDTH), 8'(GEN1_PIPEWIDTH)};

  always_comb begin
    bytes = bytes_per_beat(gen, lanes, WIDTHS);
    legal = (gen <= GEN5) && lane_legal(lanes, 5'(MAX_LANES)) && (int'(bytes) <= BUS_BYTES);
    // thermometer of the low 'bytes' bits; saturates to all ones at BUS_BYTES
    for (int i = 0; i < BUS_BYTES; i++) begin
      mask[i] = (i < int'(bytes));
    end
  end

endmodule

// File: rtl/gen_lane_ctrl.sv
// Registered generation/lane controller: qualifies PIPE beats with a link-state
// machine, settle window, legality check and saturating dropped-beat counter.
//
// state  | meaning
// DOWN   | link not trained; nothing written
// SETTLE | configuration latched, waiting out the settle window
// ACTIVE | mask loaded, beats written
// ERR    | latched configuration is illegal
module gen_lane_ctrl
  import pkt_id_pkg::*;
#(
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 16,
  parameter int GEN3_PIPEWIDTH = 32,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int BUS_BYTES      = 64,
  parameter int MAX_LANES      = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int DROP_W         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 linkup,
  input  logic [2:0]           gen,
  input  logic [4:0]           numberOfDetectedLanes,
  input  logic                 valid_pd,
  output logic [BUS_BYTES-1:0] valid,
  output logic                 w,
  output logic                 sel,
  output logic                 cfg_err,
  output logic                 cfg_ready,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  link_state_t          state;
  logic [2:0]           cfg_gen;
  logic [4:0]           cfg_lanes;
  logic [CNT_W-1:0]     cnt;
  logic [7:0]           in_bytes;
  logic [BUS_BYTES-1:0] in_mask;
  logic                 in_legal;
  logic                 cfg_change;

  gen_lane_mask #(
    .GEN1_PIPEWIDTH(GEN1_PIPEWIDTH),
    .GEN2_PIPEWIDTH(GEN2_PIPEWIDTH),
    .GEN3_PIPEWIDTH(GEN3_PIPEWIDTH),
    .GEN4_PIPEWIDTH(GEN4_PIPEWIDTH),
    .GEN5_PIPEWIDTH(GEN5_PIPEWIDTH),
    .BUS_BYTES     (BUS_BYTES),
    .MAX_LANES     (MAX_LANES)
  ) u_mask (
    .gen  (gen),
    .lanes(numberOfDetectedLanes),
    .bytes(in_bytes),
    .mask (in_mask),
    .legal(in_legal)
  );

  assign cfg_change = (gen != cfg_gen) || (numberOfDetectedLanes != cfg_lanes);
  // a pending change closes the write path before the state register reacts
  assign w          = valid_pd & linkup & (state == ACTIVE) & ~cfg_change;
  assign cfg_err    = (state == ERR);
  assign cfg_ready  = (state == ACTIVE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DOWN;
      cfg_gen   <= 3'd0;
      cfg_lanes <= 5'd0;
      cnt       <= '0;
      valid     <= '0;
      sel       <= 1'b0;
    end else if (!linkup) begin
      state <= DOWN;
      valid <= '0;
      sel   <= 1'b0;
    end else if ((state == DOWN) || cfg_change) begin
      cfg_gen   <= gen;
      cfg_lanes <= numberOfDetectedLanes;
      valid     <= '0;
      sel       <= 1'b0;
      cnt       <= CNT_W'(SETTLE_CYCLES - 1);
      state     <= in_legal ? SETTLE : ERR;
    end else if (state == SETTLE) begin
      if (cnt == '0) begin
        state <= ACTIVE;
        valid <= in_mask;
        sel   <= (int'(in_bytes) == BUS_BYTES);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (valid_pd && linkup && !w && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

// File: tb/tb_gen_lane_ctrl.sv
// Randomized and directed bench for gen_lane_ctrl against a cycle-level
// behavioural model of the link-state rules.
module tb_gen_lane_ctrl;

  localparam int SETTLE = 4;
  localparam int M_DOWN = 0, M_SET = 1, M_ACT = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        linkup = 1'b0;
  logic [2:0]  gen = 3'd0;
  logic [4:0]  lanes = 5'd0;
  logic        valid_pd = 1'b0;

  logic [63:0] valid, valid4;
  logic        w, sel, cfg_err, cfg_ready;
  logic        w4, sel4, cfg_err4, cfg_ready4;
  logic [15:0] drop_cnt;
  logic [3:0]  drop_cnt4;

  int errors = 0;
  int checks = 0;

  int m_mode = M_DOWN;
  int m_age = 0;
  int m_gen = 0;
  int m_lanes = 0;
  int m_drop = 0;
  int m_drop4 = 0;

  gen_lane_ctrl dut (
    .clk(clk), .rst(rst), .linkup(linkup), .gen(gen), .numberOfDetectedLanes(lanes),
    .valid_pd(valid_pd), .valid(valid), .w(w), .sel(sel), .cfg_err(cfg_err),
    .cfg_ready(cfg_ready), .drop_cnt(drop_cnt)
  );

  gen_lane_ctrl #(.DROP_W(4)) dut4 (
    .clk(clk), .rst(rst), .linkup(linkup), .gen(gen), .numberOfDetectedLanes(lanes),
    .valid_pd(valid_pd), .valid(valid4), .w(w4), .sel(sel4), .cfg_err(cfg_err4),
    .cfg_ready(cfg_ready4), .drop_cnt(drop_cnt4)
  );

  always #5 clk = ~clk;

  function automatic int m_bytes(input int g, input int l);
    int pw[5] = '{8, 16, 32, 8, 8};
    if (g > 4) return 0;
    return (pw[g] / 8) * l;
  endfunction

  function automatic bit m_legal(input int g, input int l);
    return (g <= 4) && ($countones(l) == 1) && (l <= 16) && (m_bytes(g, l) <= 64);
  endfunction

  function automatic logic [63:0] m_mask(input int b);
    logic [63:0] one = 64'd1;
    if (b >= 64) return {64{1'b1}};
    return (one << b) - 64'd1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit l, input int g, input int ln, input bit v);
    bit chg, act, ew;
    @(negedge clk);
    rst = r; linkup = l; gen = 3'(g); lanes = 5'(ln); valid_pd = v;
    #1;
    chg = (g != m_gen) || (ln != m_lanes);
    act = (m_mode == M_ACT);
    ew  = v && l && act && !chg;
    chk("valid", valid, act ? m_mask(m_bytes(m_gen, m_lanes)) : 64'd0);
    chk("sel", {63'd0, sel}, {63'd0, act && (m_bytes(m_gen, m_lanes) == 64)});
    chk("w", {63'd0, w}, {63'd0, ew});
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_mode == M_ERR});
    chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, act});
    chk("drop_cnt", {48'd0, drop_cnt}, 64'(m_drop));
    chk("drop_cnt4", {60'd0, drop_cnt4}, 64'(m_drop4));
    @(posedge clk);
    if (r) begin
      m_mode = M_DOWN; m_age = 0; m_gen = 0; m_lanes = 0; m_drop = 0; m_drop4 = 0;
    end else begin
      if (v && l && !ew) begin
        if (m_drop < 65535) m_drop++;
        if (m_drop4 < 15) m_drop4++;
      end
      if (!l) begin
        m_mode = M_DOWN;
      end else if (m_mode == M_DOWN || chg) begin
        m_gen = g; m_lanes = ln; m_age = 0;
        m_mode = m_legal(g, ln) ? M_SET : M_ERR;
      end else if (m_mode == M_SET) begin
        m_age++;
        if (m_age == SETTLE) m_mode = M_ACT;
      end
    end
  endtask

  task automatic hold(input int n, input int g, input int ln, input bit v);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, g, ln, v);
  endtask

  initial begin
    int lane_tab[9] = '{1, 2, 4, 8, 16, 0, 3, 12, 31};
    int rg, rl;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 0, 0, 1'b1);

    // Gen3 x4 -> 16 bytes, then w follows valid_pd
    hold(6, 2, 4, 1'b1);
    hold(2, 2, 4, 1'b0);
    hold(2, 2, 4, 1'b1);
    // Gen3 x16 full width, Gen2 x16 half width
    hold(7, 2, 16, 1'b1);
    hold(7, 1, 16, 1'b1);
    // illegal lanes -> ERR and drops, then recover
    step(1'b0, 1'b0, 1, 16, 1'b0);
    hold(4, 1, 3, 1'b1);
    hold(7, 1, 4, 1'b1);
    // in ACTIVE change gen 2->1 with valid_pd high
    hold(7, 2, 4, 1'b1);
    hold(7, 1, 4, 1'b1);
    // linkup falls in settle, with a simultaneous change that is ignored
    hold(2, 2, 4, 1'b1);
    step(1'b0, 1'b0, 0, 8, 1'b1);
    hold(7, 2, 4, 1'b1);
    // reset in ACTIVE
    step(1'b1, 1'b1, 2, 4, 1'b1);
    hold(7, 2, 4, 1'b1);
    // ERR with many beats saturates the narrow counter
    hold(22, 2, 3, 1'b1);
    hold(3, 4, 2, 1'b0);

    rg = 2; rl = 4;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) begin
        rg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        rl = lane_tab[$urandom_range(0, 8)];
      end
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, rg, rl, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
